act_dispatcher: RTL and testbench

//  Upstream front-end of count_cam. Buffers ACT commands (row, bank), resolves each row

---
 rtl/act_dispatcher_pkg.sv | 26 ++
 rtl/act_dispatcher_if.sv | 42 ++++
 rtl/act_dispatcher_fifo.sv | 52 +++++
 rtl/act_dispatcher.sv | 161 ++++++++++++++++
 tb/tb_act_dispatcher.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/act_dispatcher_pkg.sv
// Shared constants, state type and width helper for the ACT dispatcher and count_cam.
package act_dispatcher_pkg;

  localparam int unsigned N_ENTRY    = 8;
  localparam int unsigned ROW_BITS   = 16;
  localparam int unsigned BANK_BITS  = 4;
  localparam int unsigned SP_CNT_BIT = 4;
  localparam int unsigned FIFO_DEPTH = 4;

  // Index width that never collapses to zero bits for single-element ranges.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IDX_W  = idx_width(N_ENTRY);
  localparam int unsigned BANK_W = idx_width(BANK_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WR_WAIT,
    ST_SRCH_WAIT,
    ST_MISS_WAIT
  } disp_state_e;

endpackage

// File: rtl/act_dispatcher_if.sv
// ACT command input and count_cam sequencing bus of the dispatcher.
interface act_dispatcher_if
  import act_dispatcher_pkg::*;
#(
  parameter int unsigned N_ENTRY    = act_dispatcher_pkg::N_ENTRY,
  parameter int unsigned ROW_BITS   = act_dispatcher_pkg::ROW_BITS,
  parameter int unsigned BANK_BITS  = act_dispatcher_pkg::BANK_BITS,
  parameter int unsigned SP_CNT_BIT = act_dispatcher_pkg::SP_CNT_BIT
);

  localparam int unsigned IDX_W  = idx_width(N_ENTRY);
  localparam int unsigned BANK_W = idx_width(BANK_BITS);

  logic                  act_valid_i;
  logic                  act_ready_o;
  logic [ROW_BITS-1:0]   act_row_i;
  logic [BANK_W-1:0]     act_bank_i;
  logic                  cc_search_o;
  logic                  cc_write_o;
  logic [IDX_W-1:0]      cc_inc_idx_o;
  logic [BANK_W-1:0]     cc_bank_id_o;
  logic [SP_CNT_BIT-1:0] cc_sp_cnt_o;
  logic                  cc_valid_i;
  logic                  cc_hit_i;
  logic [IDX_W-1:0]      cc_addr_idx_i;
  logic                  busy_o;

  // Command source and count_cam side.
  modport master (
    output act_valid_i, act_row_i, act_bank_i, cc_valid_i, cc_hit_i, cc_addr_idx_i,
    input  act_ready_o, cc_search_o, cc_write_o, cc_inc_idx_o, cc_bank_id_o,
           cc_sp_cnt_o, busy_o
  );

  // Dispatcher side.
  modport slave (
    input  act_valid_i, act_row_i, act_bank_i, cc_valid_i, cc_hit_i, cc_addr_idx_i,
    output act_ready_o, cc_search_o, cc_write_o, cc_inc_idx_o, cc_bank_id_o,
           cc_sp_cnt_o, busy_o
  );

endinterface

// File: rtl/act_dispatcher_fifo.sv
// Synchronous FIFO buffering {row, bank} ACT commands; head is visible combinationally.
module act_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  // Full comes from the registered count only, so a push is refused when full even if a pop happens.
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; only entries behind a valid count are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/act_dispatcher.sv
// Front-end of count_cam: buffers ACTs, matches rows against the row-ID table and
// issues a write pulse on a row hit or a spillover search pulse on a row miss.
module act_dispatcher
  import act_dispatcher_pkg::*;
#(
  parameter int unsigned N_ENTRY    = act_dispatcher_pkg::N_ENTRY,
  parameter int unsigned ROW_BITS   = act_dispatcher_pkg::ROW_BITS,
  parameter int unsigned BANK_BITS  = act_dispatcher_pkg::BANK_BITS,
  parameter int unsigned SP_CNT_BIT = act_dispatcher_pkg::SP_CNT_BIT,
  parameter int unsigned FIFO_DEPTH = act_dispatcher_pkg::FIFO_DEPTH
) (
  input logic             clk_i,
  input logic             rst_ni,
  act_dispatcher_if.slave bus
);

  localparam int unsigned IDX_W  = idx_width(N_ENTRY);
  localparam int unsigned BANK_W = idx_width(BANK_BITS);
  localparam int unsigned FIFO_W = ROW_BITS + BANK_W;

  disp_state_e           state_q, state_d;
  logic [ROW_BITS-1:0]   cmd_row_q, cmd_row_d;
  logic [ROW_BITS-1:0]   tag_q [N_ENTRY];
  logic [N_ENTRY-1:0]    tag_v_q;
  logic                  tag_we;
  logic [SP_CNT_BIT-1:0] spill_q, spill_d;
  logic                  search_q, search_d;
  logic                  write_q, write_d;
  logic [IDX_W-1:0]      inc_idx_q, inc_idx_d;
  logic [BANK_W-1:0]     bank_q, bank_d;
  logic [SP_CNT_BIT-1:0] sp_out_q, sp_out_d;
  logic                  fifo_pop, fifo_empty, fifo_full;
  logic [FIFO_W-1:0]     fifo_head;
  logic [ROW_BITS-1:0]   head_row;
  logic [BANK_W-1:0]     head_bank;
  logic                  hit_any;
  logic [IDX_W-1:0]      hit_idx;

  act_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (bus.act_valid_i),
    .data_i  ({bus.act_row_i, bus.act_bank_i}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign {head_row, head_bank} = fifo_head;

  assign bus.act_ready_o  = !fifo_full;
  assign bus.cc_search_o  = search_q;
  assign bus.cc_write_o   = write_q;
  assign bus.cc_inc_idx_o = inc_idx_q;
  assign bus.cc_bank_id_o = bank_q;
  assign bus.cc_sp_cnt_o  = sp_out_q;
  assign bus.busy_o       = (state_q != ST_IDLE) || !fifo_empty;

  // Parallel tag match; a row is never held by two valid entries, so priority is irrelevant.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int unsigned k = 0; k < N_ENTRY; k++) begin
      if (tag_v_q[k] && (tag_q[k] == cmd_row_q)) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(k);
      end
    end
  end

  // Next-state and next-output decode; every count_cam output is registered from here.
  always_comb begin
    state_d   = state_q;
    cmd_row_d = cmd_row_q;
    spill_d   = spill_q;
    search_d  = 1'b0;
    write_d   = 1'b0;
    inc_idx_d = inc_idx_q;
    bank_d    = bank_q;
    sp_out_d  = sp_out_q;
    fifo_pop  = 1'b0;
    tag_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          cmd_row_d = head_row;
          bank_d    = head_bank;
          state_d   = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit_any) begin
          inc_idx_d = hit_idx;
          write_d   = 1'b1;
          state_d   = ST_WR_WAIT;
        end else begin
          sp_out_d = spill_q;
          search_d = 1'b1;
          state_d  = ST_SRCH_WAIT;
        end
      end
      ST_WR_WAIT: state_d = ST_IDLE;
      ST_SRCH_WAIT: begin
        if (bus.cc_valid_i) begin
          if (bus.cc_hit_i) begin
            tag_we  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            if (spill_q != '1) spill_d = spill_q + 1'b1;
            state_d = ST_MISS_WAIT;
          end
        end
      end
      ST_MISS_WAIT: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // FSM, command and output registers; async reset abandons any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cmd_row_q <= '0;
      spill_q   <= '0;
      search_q  <= 1'b0;
      write_q   <= 1'b0;
      inc_idx_q <= '0;
      bank_q    <= '0;
      sp_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cmd_row_q <= cmd_row_d;
      spill_q   <= spill_d;
      search_q  <= search_d;
      write_q   <= write_d;
      inc_idx_q <= inc_idx_d;
      bank_q    <= bank_d;
      sp_out_q  <= sp_out_d;
    end
  end

  // Row-table valid bits; a count_cam hit claims the reported entry for the current row.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_v_q <= '0;
    end else if (tag_we) begin
      tag_v_q[bus.cc_addr_idx_i] <= 1'b1;
    end
  end

  // Row-table tags; contents only matter where the valid bit is set.
  always_ff @(posedge clk_i) begin
    if (tag_we) tag_q[bus.cc_addr_idx_i] <= cmd_row_q;
  end

endmodule

// File: tb/tb_act_dispatcher.sv
// Randomized self-checking bench for act_dispatcher with a behavioural count_cam responder.
module tb_act_dispatcher;

  localparam int unsigned NE        = 8;
  localparam int unsigned RB        = 16;
  localparam int unsigned BB        = 4;
  localparam int unsigned SPB       = 2;
  localparam int unsigned FD        = 4;
  localparam int unsigned SP_MAX    = (1 << SPB) - 1;
  localparam int unsigned CYC_LIMIT = 300;

  typedef struct {
    logic [RB-1:0] row;
    logic [1:0]    bank;
  } act_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  act_dispatcher_if #(.N_ENTRY(NE), .ROW_BITS(RB), .BANK_BITS(BB), .SP_CNT_BIT(SPB)) bus ();

  act_dispatcher #(
    .N_ENTRY    (NE),
    .ROW_BITS   (RB),
    .BANK_BITS  (BB),
    .SP_CNT_BIT (SPB),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference state: accepted ACTs awaiting issue, row table, spillover, count_cam counts.
  act_t          acc_q[$];
  bit            tag_v   [NE];
  logic [RB-1:0] tag_row [NE];
  int unsigned   spill;
  int unsigned   last_idx;
  int unsigned   cam_cnt [NE];
  bit            hold_resp  = 1'b0;
  bit            force_miss = 1'b0;
  int unsigned   stale_req  = 0;

  function automatic int find_tag(input logic [RB-1:0] row);
    for (int k = 0; k < int'(NE); k++)
      if (tag_v[k] && tag_row[k] == row) return k;
    return -1;
  endfunction

  // Scoreboard, protocol checker and count_cam responder, all evaluated on the falling edge.
  initial begin : model
    bit            pend;
    bit            in_srch;
    bit            prev_pulse;
    int unsigned   wcnt;
    int unsigned   stale_done;
    int            k;
    int            j;
    act_t          c;
    logic [RB-1:0] cur_row;
    logic [1:0]    hb;
    logic [SPB-1:0] hs;
    logic [2:0]    hi;
    pend = 0; in_srch = 0; prev_pulse = 0; wcnt = 0; stale_done = 0; cur_row = '0;
    hb = '0; hs = '0; hi = '0;
    bus.cc_valid_i = 1'b0; bus.cc_hit_i = 1'b0; bus.cc_addr_idx_i = '0;
    forever begin
      @(negedge clk);
      bus.cc_valid_i = 1'b0;
      bus.cc_hit_i   = 1'b0;
      if (!rst_n) begin
        for (int i = 0; i < int'(NE); i++) begin tag_v[i] = 0; cam_cnt[i] = 0; end
        spill = 0; last_idx = 0; pend = 0; in_srch = 0; prev_pulse = 0;
        stale_done = stale_req;
        continue;
      end
      if (in_srch) begin
        check_eq("srch_bank_stable", bus.cc_bank_id_o, hb);
        check_eq("srch_sp_stable", bus.cc_sp_cnt_o, hs);
        check_eq("srch_idx_stable", bus.cc_inc_idx_o, hi);
      end
      if (bus.cc_search_o || bus.cc_write_o) begin
        check_eq("pulse_overlap", bus.cc_search_o & bus.cc_write_o, 0);
        check_eq("pulse_width", prev_pulse, 0);
        if (acc_q.size() == 0) begin
          check_eq("unexpected_pulse", bus.cc_search_o | bus.cc_write_o, 0);
        end else begin
          c = acc_q.pop_front();
          k = find_tag(c.row);
          check_eq("pulse_bank", bus.cc_bank_id_o, c.bank);
          if (k >= 0) begin
            check_eq("expect_write", bus.cc_write_o, 1);
            check_eq("write_idx", bus.cc_inc_idx_o, k);
            last_idx = k;
            cam_cnt[k]++;
          end else begin
            check_eq("expect_search", bus.cc_search_o, 1);
            check_eq("search_sp_cnt", bus.cc_sp_cnt_o, spill);
            check_eq("search_held_idx", bus.cc_inc_idx_o, last_idx);
          end
          if (bus.cc_search_o) begin
            pend = 1; in_srch = 1; cur_row = c.row;
            wcnt = $urandom_range(0, NE + 1);
            hb = bus.cc_bank_id_o; hs = bus.cc_sp_cnt_o; hi = bus.cc_inc_idx_o;
          end
        end
      end else if (stale_done != stale_req) begin
        stale_done++;
        bus.cc_valid_i = 1'b1; bus.cc_hit_i = 1'b1; bus.cc_addr_idx_i = 3'd3;
      end else if (pend) begin
        if (wcnt > 0) wcnt--;
        else if (!hold_resp) begin
          j = -1;
          if (!force_miss)
            for (int i = int'(NE) - 1; i >= 0; i--) if (cam_cnt[i] == spill) j = i;
          bus.cc_valid_i = 1'b1;
          if (j >= 0) begin
            bus.cc_hit_i = 1'b1; bus.cc_addr_idx_i = 3'(j);
            cam_cnt[j]++;
            tag_row[j] = cur_row; tag_v[j] = 1;
          end else begin
            bus.cc_hit_i = 1'b0; bus.cc_addr_idx_i = 3'($urandom_range(0, NE - 1));
            spill = (spill < SP_MAX) ? spill + 1 : SP_MAX;
          end
          pend = 0; in_srch = 0;
        end
      end
      prev_pulse = bus.cc_search_o | bus.cc_write_o;
    end
  end

  // Present one ACT from a falling edge and hold it until accepted.
  task automatic push(input logic [RB-1:0] row, input logic [1:0] bank, output int unsigned waited);
    bus.act_valid_i = 1'b1; bus.act_row_i = row; bus.act_bank_i = bank;
    waited = 0;
    while (!bus.act_ready_o && waited < CYC_LIMIT) begin @(negedge clk); waited++; end
    if (bus.act_ready_o) begin
      acc_q.push_back('{row, bank});
      @(negedge clk);
    end else begin
      check_eq("push_timeout", bus.act_ready_o, 1);
    end
    bus.act_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((bus.busy_o || acc_q.size() != 0) && n < CYC_LIMIT) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    check_eq("idle_reached", bus.busy_o, 0);
  endtask

  task automatic wait_search();
    int unsigned n = 0;
    while (!bus.cc_search_o && n < CYC_LIMIT) begin @(negedge clk); n++; end
    check_eq("search_seen", bus.cc_search_o, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    int unsigned   w;
    logic [RB-1:0] rows [8];
    logic [RB-1:0] pool [12];
    logic [RB-1:0] r;
    int unsigned   n;
    bus.act_valid_i = 1'b0; bus.act_row_i = '0; bus.act_bank_i = '0;

    // Reset values
    #1;
    check_eq("rst_ready", bus.act_ready_o, 1);
    check_eq("rst_search", bus.cc_search_o, 0);
    check_eq("rst_write", bus.cc_write_o, 0);
    check_eq("rst_inc_idx", bus.cc_inc_idx_o, 0);
    check_eq("rst_bank", bus.cc_bank_id_o, 0);
    check_eq("rst_busy", bus.busy_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: first ACT searches with spillover 0, the repeat becomes a write to entry 0
    push(16'h0010, 2'd2, w);
    wait_search();
    check_eq("t1_sp_cnt", bus.cc_sp_cnt_o, 0);
    check_eq("t1_bank", bus.cc_bank_id_o, 2);
    wait_idle();
    push(16'h0010, 2'd2, w);
    check_eq("t1_write_c1", bus.cc_write_o, 0);
    @(negedge clk);
    check_eq("t1_write_c2", bus.cc_write_o, 0);
    @(negedge clk);
    check_eq("t1_write_c3", bus.cc_write_o, 1);
    check_eq("t1_write_idx", bus.cc_inc_idx_o, 0);
    @(negedge clk);
    check_eq("t1_write_c4", bus.cc_write_o, 0);
    wait_idle();

    // 2: fill the table with distinct rows, each activated twice, then one more new row misses
    rows[0] = 16'h0010;
    for (int i = 1; i < 8; i++) rows[i] = RB'(32'h1000 * i) | RB'($urandom_range(0, 255));
    for (int i = 1; i < 8; i++) begin
      for (int t = 0; t < 2; t++) begin
        push(rows[i], 2'($urandom_range(0, 3)), w);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    wait_idle();
    push(16'h9000 | RB'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), w);
    n = 0;
    while (n < CYC_LIMIT) begin @(negedge clk); #1; if (bus.cc_valid_i) break; n++; end
    check_eq("t2_resp_seen", bus.cc_valid_i, 1);
    @(negedge clk);
    check_eq("t2_busy_miss_wait", bus.busy_o, 1);
    @(negedge clk);
    check_eq("t2_busy_after_miss", bus.busy_o, 0);
    for (int i = 0; i < 8; i++) push(rows[i], 2'($urandom_range(0, 3)), w);
    wait_idle();

    // 4: repeated misses drive spillover to its ceiling without wrapping
    force_miss = 1'b1;
    for (int i = 0; i < 4; i++) push(16'hA000 | RB'(i * 256) | RB'($urandom_range(0, 255)), 2'(i), w);
    wait_idle();
    force_miss = 1'b0;

    // 3: stall the FSM in a search, fill the FIFO back-to-back, the fifth ACT sees no ready
    hold_resp = 1'b1;
    push(16'hC000 | RB'($urandom_range(0, 255)), 2'd1, w);
    wait_search();
    push(rows[3], 2'd0, w);
    check_eq("t3_accept0", w, 0);
    push(16'hC100 | RB'($urandom_range(0, 255)), 2'd3, w);
    check_eq("t3_accept1", w, 0);
    push(rows[5], 2'd2, w);
    check_eq("t3_accept2", w, 0);
    push(rows[3], 2'd1, w);
    check_eq("t3_accept3", w, 0);
    bus.act_valid_i = 1'b1; bus.act_row_i = 16'hC200; bus.act_bank_i = 2'd0;
    for (int i = 0; i < 3; i++) begin
      check_eq("t3_full_not_ready", bus.act_ready_o, 0);
      @(negedge clk);
    end
    bus.act_valid_i = 1'b0;
    hold_resp = 1'b0;
    wait_idle();
    check_eq("t3_all_issued", acc_q.size(), 0);

    // Random traffic over a small row pool with idle gaps
    for (int i = 0; i < 12; i++) pool[i] = (i < 6) ? rows[i] : (16'hD000 | RB'(i * 16));
    for (int i = 0; i < 40; i++) begin
      r = pool[$urandom_range(0, 11)];
      push(r, 2'($urandom_range(0, 3)), w);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();

    // 5: async reset during a pending search, then a stale count_cam response
    hold_resp = 1'b1;
    push(16'hBEEF, 2'd1, w);
    wait_search();
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_search_cleared", bus.cc_search_o, 0);
    check_eq("t5_write_cleared", bus.cc_write_o, 0);
    check_eq("t5_idx_cleared", bus.cc_inc_idx_o, 0);
    check_eq("t5_bank_cleared", bus.cc_bank_id_o, 0);
    check_eq("t5_busy_cleared", bus.busy_o, 0);
    check_eq("t5_ready_set", bus.act_ready_o, 1);
    acc_q.delete();
    hold_resp = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stale_req++;
    repeat (6) begin
      @(negedge clk);
      check_eq("t5_no_search", bus.cc_search_o, 0);
      check_eq("t5_no_write", bus.cc_write_o, 0);
      check_eq("t5_not_busy", bus.busy_o, 0);
    end
    push(16'hBEEF, 2'd1, w);
    wait_search();
    check_eq("t5_post_sp_cnt", bus.cc_sp_cnt_o, 0);
    wait_idle();
    check_eq("final_all_issued", acc_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
